// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared DMA request/ack protocol types and constants
//
// Purpose: state encoding for the DMA memory responder and the address /
// length widths shared with the DMA initiator.
// Ports: none (package).
package dma_pkg;

  localparam int unsigned DMA_AW     = 24;  // word address width (byte addr [25:2])
  localparam int unsigned DMA_LW     = 6;   // burst length width, one-based
  localparam int unsigned DMA_MAXLEN = 32;  // default maximum burst length

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_XFER,
    ST_WAITR,
    ST_ACK,
    ST_DONE
  } dma_state_e;

endpackage

// File: rtl/dma_win_chk.sv
// rtl/dma_win_chk.sv - combinational burst window and length checker
//
// Purpose: flags a burst as illegal when its length is zero or above MAXLEN,
// when it starts below WIN_LO, or when its last word lies above WIN_HI
// (including a carry out of the address width).
// Ports:
//   addr_i  burst start word address
//   len_i   burst length in words, one-based
//   viol_o  1 = burst is illegal
module dma_win_chk
  import dma_pkg::*;
#(
  parameter int unsigned         MAXLEN = DMA_MAXLEN,
  parameter logic [DMA_AW-1:0]   WIN_LO = '0,
  parameter logic [DMA_AW-1:0]   WIN_HI = '1
) (
  input  logic [DMA_AW-1:0] addr_i,
  input  logic [DMA_LW-1:0] len_i,
  output logic              viol_o
);

  // One extra bit so a burst running past the top of the address space
  // shows up as an end address above WIN_HI instead of wrapping.
  logic [DMA_AW:0] end_addr;
  logic            len_zero;
  logic            len_big;
  logic            below_lo;
  logic            above_hi;

  assign end_addr = {1'b0, addr_i} + (DMA_AW+1)'(len_i) - (DMA_AW+1)'(1);
  assign len_zero = (len_i == '0);
  assign len_big  = (32'(len_i) > MAXLEN);
  // A leading 1 on both operands leaves the ordering unchanged.
  assign below_lo = ({1'b1, addr_i} < {1'b1, WIN_LO});
  assign above_hi = (end_addr > {1'b0, WIN_HI});

  assign viol_o = len_zero | len_big | below_lo | above_hi;

endmodule

// File: rtl/dma_mem_resp.sv
// rtl/dma_mem_resp.sv - memory-side responder for the f2m/m2f DMA protocol
//
// Purpose: accepts one burst at a time from the DMA initiator, checks it
// against the legal window, then runs single-word accesses on an SRAM-style
// port, strobing frvalid/fwvalid per word and pulsing ack at burst end.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   f2m_req/write/addr/len/wdata   burst request from the initiator
//   m2f_ack/viol      end-of-transaction pulse and violation flag
//   m2f_frvalid       write word consumed this cycle
//   m2f_fwvalid       m2f_rdata carries a read word this cycle
//   m2f_rdata         read data toward the initiator
//   mem_req/we/addr/wdata          access request to memory
//   mem_gnt           memory accepts the access this cycle
//   mem_rvalid/rdata  in-order read data return
module dma_mem_resp
  import dma_pkg::*;
#(
  parameter int unsigned         MAXLEN = DMA_MAXLEN,
  parameter logic [DMA_AW-1:0]   WIN_LO = 24'h000000,
  parameter logic [DMA_AW-1:0]   WIN_HI = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f2m_req,
  input  logic              f2m_write,
  input  logic [DMA_AW-1:0] f2m_addr,
  input  logic [DMA_LW-1:0] f2m_len,
  input  logic [31:0]       f2m_wdata,
  output logic              m2f_ack,
  output logic              m2f_viol,
  output logic              m2f_frvalid,
  output logic              m2f_fwvalid,
  output logic [31:0]       m2f_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DMA_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  dma_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [DMA_AW-1:0] addr_q, addr_d;
  logic [DMA_LW-1:0] len_q, len_d;
  logic              viol_q, viol_d;
  logic [DMA_LW-1:0] beats_q, beats_d;
  logic [DMA_AW-1:0] cur_addr_q, cur_addr_d;
  logic              chk_viol;

  dma_win_chk #(
    .MAXLEN (MAXLEN),
    .WIN_LO (WIN_LO),
    .WIN_HI (WIN_HI)
  ) u_win_chk (
    .addr_i (addr_q),
    .len_i  (len_q),
    .viol_o (chk_viol)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      viol_q     <= 1'b0;
      beats_q    <= '0;
      cur_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      viol_q     <= viol_d;
      beats_q    <= beats_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    len_d       = len_q;
    viol_d      = viol_q;
    beats_d     = beats_q;
    cur_addr_d  = cur_addr_q;
    m2f_ack     = 1'b0;
    m2f_viol    = 1'b0;
    m2f_frvalid = 1'b0;
    m2f_fwvalid = 1'b0;
    m2f_rdata   = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (f2m_req) begin
          write_d = f2m_write;
          addr_d  = f2m_addr;
          len_d   = f2m_len;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        viol_d = chk_viol;
        if (chk_viol) begin
          state_d = ST_ACK;
        end else begin
          beats_d    = len_q;
          cur_addr_d = addr_q;
          state_d    = ST_XFER;
        end
      end

      ST_XFER: begin
        mem_req   = 1'b1;
        mem_we    = write_q;
        mem_addr  = cur_addr_q;
        mem_wdata = write_q ? f2m_wdata : '0;
        if (mem_gnt) begin
          cur_addr_d = cur_addr_q + 1'b1;
          beats_d    = beats_q - 1'b1;
          if (write_q) begin
            // Initiator advances f2m_wdata on this edge.
            m2f_frvalid = 1'b1;
            if (beats_q == 6'd1) begin
              state_d = ST_ACK;
            end
          end else begin
            state_d = ST_WAITR;
          end
        end
      end

      ST_WAITR: begin
        if (mem_rvalid) begin
          m2f_fwvalid = 1'b1;
          m2f_rdata   = mem_rdata;
          // beats_q was already decremented when this read was granted.
          state_d     = (beats_q != '0) ? ST_XFER : ST_ACK;
        end
      end

      ST_ACK: begin
        m2f_ack  = 1'b1;
        m2f_viol = viol_q;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        // Request stays high in the cycle after ack; do not re-accept it.
        if (!f2m_req) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_mem_resp.sv
// tb/tb_dma_mem_resp.sv - table-driven bench for dma_mem_resp
module tb_dma_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        f2m_req;
  logic        f2m_write;
  logic [23:0] f2m_addr;
  logic [5:0]  f2m_len;
  logic [31:0] f2m_wdata;
  logic        m2f_ack;
  logic        m2f_viol;
  logic        m2f_frvalid;
  logic        m2f_fwvalid;
  logic [31:0] m2f_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dma_mem_resp dut (
    .clk         (clk),
    .rst         (rst),
    .f2m_req     (f2m_req),
    .f2m_write   (f2m_write),
    .f2m_addr    (f2m_addr),
    .f2m_len     (f2m_len),
    .f2m_wdata   (f2m_wdata),
    .m2f_ack     (m2f_ack),
    .m2f_viol    (m2f_viol),
    .m2f_frvalid (m2f_frvalid),
    .m2f_fwvalid (m2f_fwvalid),
    .m2f_rdata   (m2f_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [5:0]  len;
    logic        gtog;        // grant pattern 1,0,1,0 instead of tied high
    logic        hold;        // keep req high one extra cycle past ack
    int          abort_after; // reset after this many read words (0 = never)
    int          exp_ack;     // cycle of ack counted from first req cycle, -1 = none
    logic        exp_viol;
    int          exp_nacc;
    int          exp_nfr;
    int          exp_nfw;
  } vec_t;

  vec_t vt[12];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [23:0] a);
    return {8'hC3, a};
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int          cyc, nacc, nfr, nfw, ack_cyc, extra, hs_err, end_cyc, k, widx, rv_cnt, phase;
    logic        got_ack, viol_seen;
    logic [31:0] wbase, rd_data;
    logic [23:0] ea;
    string       tag;
    cyc = 0; nacc = 0; nfr = 0; nfw = 0; ack_cyc = -1; extra = 0; hs_err = 0;
    end_cyc = 400; k = 0; widx = 0; rv_cnt = 0; phase = 0;
    got_ack = 1'b0; viol_seen = 1'b0; rd_data = '0;
    wbase = 32'hA500_0000 | (idx << 16);
    tag = $sformatf("v%0d", idx);
    while (cyc < end_cyc) begin
      @(posedge clk); #1;
      rst = (phase == 1);
      if (phase >= 1) f2m_req = 1'b0;
      else f2m_req = !got_ack || (cyc <= ack_cyc + (v.hold ? 1 : 0));
      // Request fields are only meaningful in the first cycle; scramble afterwards.
      f2m_write = (cyc == 0) ? v.wr : ~v.wr;
      f2m_addr  = (cyc == 0) ? v.addr : ~v.addr;
      f2m_len   = (cyc == 0) ? v.len : 6'h2A;
      f2m_wdata = wbase + widx;
      mem_gnt   = v.gtog ? (mem_req && (k % 2 == 0)) : 1'b1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
      if (rv_cnt != 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_data;
        end
      end
      @(negedge clk);
      if (phase == 1) begin
        phase = 2;
      end else begin
        if (phase == 2) begin
          check({tag, " rst_ctl"}, {m2f_ack, m2f_viol, m2f_frvalid, m2f_fwvalid, mem_req, mem_we, mem_addr}, 64'd0);
          check({tag, " rst_data"}, {m2f_rdata, mem_wdata}, 64'd0);
          phase = 3;
        end
        if (phase == 0) begin
          if (mem_req) begin
            ea = v.addr + 24'(nacc);
            check({tag, " mem_addr"}, mem_addr, ea);
            check({tag, " mem_we"}, mem_we, v.wr);
            if (mem_gnt) begin
              if (!v.wr) begin
                rv_cnt  = 2;
                rd_data = rd_model(ea);
              end
              nacc++;
            end
            k++;
          end
          if (m2f_frvalid) begin
            check({tag, " wdata"}, mem_wdata, wbase + widx);
            widx++;
            nfr++;
          end
          if (m2f_fwvalid) begin
            ea = v.addr + 24'(nfw);
            check({tag, " rdata"}, m2f_rdata, rd_model(ea));
            nfw++;
          end
          if ((m2f_frvalid && m2f_fwvalid) || (m2f_ack && (m2f_frvalid || m2f_fwvalid)) ||
              (m2f_frvalid != (mem_req && mem_gnt && mem_we)))
            hs_err++;
          if (v.abort_after != 0 && nfw == v.abort_after) begin
            phase   = 1;
            end_cyc = cyc + 6;
            rv_cnt  = 0;
          end
        end
        if (m2f_ack) begin
          if (got_ack) extra++;
          else begin
            got_ack   = 1'b1;
            ack_cyc   = cyc;
            viol_seen = m2f_viol;
            end_cyc   = cyc + 4;
          end
        end
      end
      cyc++;
    end
    check({tag, " ack_cycle"}, ack_cyc, v.exp_ack);
    if (v.exp_ack >= 0) check({tag, " viol"}, viol_seen, v.exp_viol);
    check({tag, " accesses"}, nacc, v.exp_nacc);
    check({tag, " frvalid_count"}, nfr, v.exp_nfr);
    check({tag, " fwvalid_count"}, nfw, v.exp_nfw);
    check({tag, " handshake_errs"}, hs_err, 0);
    check({tag, " extra_acks"}, extra, 0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr    addr          len    gtog  hold  abort ack viol   nacc nfr nfw
    vt[0]  = '{1'b1, 24'h000100, 6'd4,  1'b0, 1'b0, 0,  6,  1'b0,  4,   4,  0};
    vt[1]  = '{1'b0, 24'h000200, 6'd8,  1'b0, 1'b0, 0,  26, 1'b0,  8,   0,  8};
    vt[2]  = '{1'b1, 24'h000300, 6'd0,  1'b0, 1'b0, 0,  2,  1'b1,  0,   0,  0};
    vt[3]  = '{1'b0, 24'h000000, 6'd33, 1'b0, 1'b0, 0,  2,  1'b1,  0,   0,  0};
    vt[4]  = '{1'b1, 24'hFFFFFF, 6'd2,  1'b0, 1'b0, 0,  2,  1'b1,  0,   0,  0};
    vt[5]  = '{1'b1, 24'h000400, 6'd4,  1'b1, 1'b0, 0,  9,  1'b0,  4,   4,  0};
    vt[6]  = '{1'b1, 24'h000500, 6'd2,  1'b0, 1'b1, 0,  4,  1'b0,  2,   2,  0};
    vt[7]  = '{1'b0, 24'h000600, 6'd1,  1'b0, 1'b0, 0,  5,  1'b0,  1,   0,  1};
    vt[8]  = '{1'b1, 24'hFFFFFF, 6'd1,  1'b0, 1'b0, 0,  3,  1'b0,  1,   1,  0};
    vt[9]  = '{1'b1, 24'h000000, 6'd32, 1'b0, 1'b0, 0,  34, 1'b0,  32,  32, 0};
    vt[10] = '{1'b0, 24'h000700, 6'd8,  1'b0, 1'b0, 3,  -1, 1'b0,  3,   0,  3};
    vt[11] = '{1'b1, 24'h000800, 6'd3,  1'b0, 1'b0, 0,  5,  1'b0,  3,   3,  0};

    rst = 1'b1; f2m_req = 1'b0; f2m_write = 1'b0; f2m_addr = '0; f2m_len = '0;
    f2m_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", {m2f_ack, m2f_viol, m2f_frvalid, m2f_fwvalid, mem_req, mem_we, mem_addr}, 64'd0);
    check("reset_data", {m2f_rdata, mem_wdata}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i, vt[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
